ddr4_cal_rd_return: RTL and testbench
=====================================

Name: ddr4_cal_rd_return

Overview:
- Receive-side counterpart of the PI read-enable/read-issue path. It tracks each post-calibration read CAS as a tag: buffer address, inject flag and RMW flag.
- It pops the PHY read-data FIFOs once every byte lane holds data, and returns the data to the MC read buffer with rdDataEn/rdDataAddr.
- It sits between the PHY byte-lane RX FIFOs and the MC read-data interface, and detects tag/data mismatches and stalls.

Parameters:
DBYTES, 4, number of byte lanes
DBAW, 5, read-buffer address width
TAG_DEPTH, 16, outstanding-read tag FIFO depth (power of 2)
SKEW_MAX, 15, cycles some-but-not-all lanes may be non-empty before error
TO_MARGIN, 32, cycles beyond max_rd_lat before head-tag timeout
TCQ, 0.1, simulation clock-to-q

Ports:
clk  in  1  fabric clock
rst_n  in  1  asynchronous active-low reset
calDone  in  1  calibration complete; low = block in CAL state
mcrdCAS  in  1  MC read CAS issued this cycle
winBuf  in  DBAW  read-buffer address of the CAS
winInjTxn  in  1  ECC-inject transaction flag
winRmw  in  1  read-modify-write flag
max_rd_lat  in  7  calibrated read latency, in fabric cycles
phy2clb_fifo_empty  in  DBYTES  per-lane RX FIFO empty
phy2clb_rd_dq  in  DBYTES*64  per-lane RX FIFO head data (8 beats x 8 bits)
mc_clb2phy_fifo_rden  out  DBYTES  per-lane RX FIFO pop
rdData  out  DBYTES*64  returned read data
rdDataEn  out  1  rdData valid
rdDataAddr  out  DBAW  buffer address for rdData
rdDataEnd  out  1  last beat of burst; equals rdDataEn (BL8 = one fabric beat)
rdInj  out  1  inject flag of returned tag
rdRmw  out  1  RMW flag of returned tag
outstanding  out  $clog2(TAG_DEPTH)+1  tags in flight
tag_ovf_err  out  1  sticky: CAS arrived with tag FIFO full
orphan_err  out  1  sticky: all lanes non-empty with no tag
skew_err  out  1  sticky: lane skew exceeded SKEW_MAX
rd_timeout_err  out  1  sticky: head tag exceeded max_rd_lat+TO_MARGIN

Behaviour:
- Reset (rst_n low, async): all outputs 0, tag FIFO empty, counters 0, state CAL.
- States:
  - CAL -> RUN on calDone=1.
  - RUN -> CAL on calDone=0. This synchronously flushes tags and counters; sticky errors are kept.
  - RUN -> HALT on any error set.
  - HALT leaves only on reset. In HALT, rden is held 0 and pushes are ignored.
- Push: in RUN, mcrdCAS=1 pushes {winBuf,winInjTxn,winRmw}. If the FIFO is full and no pop occurs that cycle, the tag is dropped and tag_ovf_err is set.
  - Push+pop in the same cycle while full is legal; count is unchanged.
- Pop condition (RUN): tag FIFO non-empty AND phy2clb_fifo_empty == 0 (all lanes).
  - When it holds, drive mc_clb2phy_fifo_rden to all ones for exactly that cycle N.
  - Capture phy2clb_rd_dq and the head tag in cycle N.
  - Present the captured data and tag on rdData/rdDataAddr/rdInj/rdRmw with rdDataEn=rdDataEnd=1 in cycle N+1. Latency from pop to rdDataEn is 1 cycle.
  - Back-to-back pops are allowed every cycle.
- rdData holds its last value when rdDataEn=0. rdInj/rdRmw are 0 when rdDataEn=0.
- Skew counter:
  - Increments while some but not all lanes are non-empty.
  - Clears when all lanes are empty or on a pop.
  - Reaching SKEW_MAX+1 sets skew_err.
- Orphan: all lanes non-empty AND tag FIFO empty in RUN sets orphan_err immediately; no pop occurs.
- Age counter:
  - Counts while the tag FIFO is non-empty; clears on a pop or when the FIFO is empty. Saturates at 255.
  - Age > max_rd_lat + TO_MARGIN sets rd_timeout_err. The comparison is 8-bit unsigned.
- outstanding = FIFO occupancy. Pointers are $clog2(TAG_DEPTH)+1 bits with a wrap bit; full = MSBs differ and LSBs equal.
- mcrdCAS in CAL is ignored; no error is raised.

Decomposition:
- Shared package ddr4_cal_rd_return_pkg:
  - tag struct {addr[DBAW], inj, rmw}
  - state enum {CAL, RUN, HALT}
  - SKEW_MAX/TO_MARGIN defaults
- One sub-module, ddr4_cal_rd_tag_fifo: synchronous FIFO with push/pop/full/empty/count and a registered head output, holding the tags.

Test Plan:
1. After reset, calDone=1; CAS with winBuf=5, then lanes go non-empty 10 cycles later with data 0xA5.. -> rden=4'hF for one cycle; the next cycle has rdDataEn=1, rdDataAddr=5, rdData=0xA5..
2. Three CAS with addr 1,2,3, then data on three consecutive cycles -> three back-to-back rdDataEn with addresses 1,2,3 in order; outstanding goes 3,2,1,0.
3. Seventeen CAS with no returns (TAG_DEPTH=16) -> tag_ovf_err=1 on the 17th; outstanding=16; state HALT.
4. Lane 0 non-empty and lanes 1-3 empty for 16 cycles -> skew_err=1; no rden pulse.
5. One CAS with max_rd_lat=20 and no data -> rd_timeout_err=1 when age reaches 53; rden stays 0 afterwards.
6. Two tags outstanding, calDone drops for one cycle -> outstanding=0, no error; then all lanes non-empty with calDone=1 -> orphan_err=1.

Source files
------------

// File: rtl/ddr4_cal_rd_return_pkg.sv
// Shared types and defaults for the post-calibration read-return path.
package ddr4_cal_rd_return_pkg;

   // Tag address width. The tag struct is sized from this, so the top's DBAW
   // must stay equal to it.
   localparam int TAG_AW        = 5;
   localparam int SKEW_MAX_DEF  = 15;
   localparam int TO_MARGIN_DEF = 32;

   // One outstanding read: where it lands in the MC buffer plus its flags.
   typedef struct packed {
      logic [TAG_AW-1:0] addr;
      logic              inj;
      logic              rmw;
   } rd_tag_t;

   typedef enum logic [1:0] {
      ST_CAL  = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } cal_state_e;

   // 8-bit increment that sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ddr4_cal_rd_tag_fifo.sv
// Tag FIFO: wrap-bit pointers, registered head, same-cycle push+pop when full.
module ddr4_cal_rd_tag_fifo #(
   parameter int W     = 7,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_din,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [W-1:0]             o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic         w_wr_en, w_rd_en;

   assign o_empty  = (r_wr_ptr == r_rd_ptr);
   assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count  = r_wr_ptr - r_rd_ptr;
   assign w_rd_en  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still accept.
   assign w_wr_en  = i_push && (!o_full || w_rd_en);
   assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_en};

   // Storage array, no reset needed: only slots between the pointers are read.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

   // Pointer update; flush empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         r_rd_ptr <= w_rd_nxt;
      end
   end

   // Registered head: bypass the incoming tag when it becomes the new head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       o_head <= '0;
      else if (i_flush) o_head <= '0;
      else if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]))
                        o_head <= i_din;
      else              o_head <= r_mem[w_rd_nxt[AW-1:0]];
   end

endmodule

// File: rtl/ddr4_cal_rd_return.sv
// Read-return path: tracks read tags, pops PHY RX FIFOs when all lanes have
// data, returns the beat to the MC read buffer and flags tag/data faults.
module ddr4_cal_rd_return
   import ddr4_cal_rd_return_pkg::*;
#(
   parameter int DBYTES    = 4,
   parameter int DBAW      = TAG_AW,
   parameter int TAG_DEPTH = 16,
   parameter int SKEW_MAX  = SKEW_MAX_DEF,
   parameter int TO_MARGIN = TO_MARGIN_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           calDone,
   input  logic                           mcrdCAS,
   input  logic [DBAW-1:0]                winBuf,
   input  logic                           winInjTxn,
   input  logic                           winRmw,
   input  logic [6:0]                     max_rd_lat,
   input  logic [DBYTES-1:0]              phy2clb_fifo_empty,
   input  logic [DBYTES*64-1:0]           phy2clb_rd_dq,
   output logic [DBYTES-1:0]              mc_clb2phy_fifo_rden,
   output logic [DBYTES*64-1:0]           rdData,
   output logic                           rdDataEn,
   output logic [DBAW-1:0]                rdDataAddr,
   output logic                           rdDataEnd,
   output logic                           rdInj,
   output logic                           rdRmw,
   output logic [$clog2(TAG_DEPTH):0]     outstanding,
   output logic                           tag_ovf_err,
   output logic                           orphan_err,
   output logic                           skew_err,
   output logic                           rd_timeout_err
);

   cal_state_e r_state;
   rd_tag_t    w_cas_tag, w_head;
   logic       w_run, w_flush, w_all_nempty, w_all_empty, w_skewed;
   logic       w_pop, w_push, w_ovf, w_orphan, w_skew_hit, w_to_hit, w_any_err;
   logic       w_tf_full, w_tf_empty;
   logic [7:0] r_skew_cnt, r_age, w_skew_nxt, w_age_nxt, w_to_thr;

   // Dropping calDone acts in the same cycle: no pushes/pops/errors, flush.
   assign w_run        = (r_state == ST_RUN) && calDone;
   assign w_flush      = (r_state == ST_CAL) || ((r_state == ST_RUN) && !calDone);
   assign w_all_nempty = (phy2clb_fifo_empty == '0);
   assign w_all_empty  = &phy2clb_fifo_empty;
   assign w_skewed     = !w_all_nempty && !w_all_empty;

   assign w_pop        = w_run && !w_tf_empty && w_all_nempty;
   assign w_push       = w_run && mcrdCAS;
   assign w_ovf        = w_push && w_tf_full && !w_pop;
   assign w_orphan     = w_run && w_all_nempty && w_tf_empty;

   assign w_skew_nxt   = (w_pop || !w_skewed) ? 8'd0 : sat_inc8(r_skew_cnt);
   assign w_skew_hit   = w_run && (w_skew_nxt >= 8'(SKEW_MAX + 1));
   assign w_age_nxt    = (w_pop || w_tf_empty) ? 8'd0 : sat_inc8(r_age);
   assign w_to_thr     = {1'b0, max_rd_lat} + 8'(TO_MARGIN);
   assign w_to_hit     = w_run && (w_age_nxt > w_to_thr);
   assign w_any_err    = w_ovf || w_orphan || w_skew_hit || w_to_hit;

   assign w_cas_tag            = {winBuf, winInjTxn, winRmw};
   assign mc_clb2phy_fifo_rden = {DBYTES{w_pop}};

   ddr4_cal_rd_tag_fifo #(
      .W     ($bits(rd_tag_t)),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_din   (w_cas_tag),
      .i_pop   (w_pop),
      .o_full  (w_tf_full),
      .o_empty (w_tf_empty),
      .o_count (outstanding),
      .o_head  (w_head)
   );

   // Skew and head-tag age counters; both idle at zero outside RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skew_cnt <= '0;
         r_age      <= '0;
      end else if (!w_run) begin
         r_skew_cnt <= '0;
         r_age      <= '0;
      end else begin
         r_skew_cnt <= w_skew_nxt;
         r_age      <= w_age_nxt;
      end
   end

   // Control FSM with registered return beat and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_CAL;
         rdData         <= '0;
         rdDataEn       <= 1'b0;
         rdDataEnd      <= 1'b0;
         rdDataAddr     <= '0;
         rdInj          <= 1'b0;
         rdRmw          <= 1'b0;
         tag_ovf_err    <= 1'b0;
         orphan_err     <= 1'b0;
         skew_err       <= 1'b0;
         rd_timeout_err <= 1'b0;
      end else begin
         rdDataEn  <= w_pop;
         rdDataEnd <= w_pop;
         rdInj     <= w_pop && w_head.inj;
         rdRmw     <= w_pop && w_head.rmw;
         if (w_pop) begin
            rdData     <= phy2clb_rd_dq;
            rdDataAddr <= w_head.addr;
         end
         if (w_ovf)      tag_ovf_err    <= 1'b1;
         if (w_orphan)   orphan_err     <= 1'b1;
         if (w_skew_hit) skew_err       <= 1'b1;
         if (w_to_hit)   rd_timeout_err <= 1'b1;
         case (r_state)
            ST_CAL:  if (calDone) r_state <= ST_RUN;
            ST_RUN: begin
               if (!calDone)       r_state <= ST_CAL;
               else if (w_any_err) r_state <= ST_HALT;
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_CAL;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr4_cal_rd_return.sv
// Bench for ddr4_cal_rd_return: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_ddr4_cal_rd_return;

   localparam int DBYTES    = 4;
   localparam int DBAW      = 5;
   localparam int TAG_DEPTH = 16;
   localparam int SKEW_MAX  = 15;
   localparam int TO_MARGIN = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 calDone, mcrdCAS, winInjTxn, winRmw;
   logic [DBAW-1:0]      winBuf;
   logic [6:0]           max_rd_lat;
   logic [DBYTES-1:0]    phy2clb_fifo_empty;
   logic [DBYTES*64-1:0] phy2clb_rd_dq;
   logic [DBYTES-1:0]    mc_clb2phy_fifo_rden;
   logic [DBYTES*64-1:0] rdData;
   logic                 rdDataEn, rdDataEnd, rdInj, rdRmw;
   logic [DBAW-1:0]      rdDataAddr;
   logic [$clog2(TAG_DEPTH):0] outstanding;
   logic                 tag_ovf_err, orphan_err, skew_err, rd_timeout_err;

   ddr4_cal_rd_return #(
      .DBYTES(DBYTES), .DBAW(DBAW), .TAG_DEPTH(TAG_DEPTH),
      .SKEW_MAX(SKEW_MAX), .TO_MARGIN(TO_MARGIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .calDone(calDone), .mcrdCAS(mcrdCAS),
      .winBuf(winBuf), .winInjTxn(winInjTxn), .winRmw(winRmw),
      .max_rd_lat(max_rd_lat), .phy2clb_fifo_empty(phy2clb_fifo_empty),
      .phy2clb_rd_dq(phy2clb_rd_dq), .mc_clb2phy_fifo_rden(mc_clb2phy_fifo_rden),
      .rdData(rdData), .rdDataEn(rdDataEn), .rdDataAddr(rdDataAddr),
      .rdDataEnd(rdDataEnd), .rdInj(rdInj), .rdRmw(rdRmw),
      .outstanding(outstanding), .tag_ovf_err(tag_ovf_err),
      .orphan_err(orphan_err), .skew_err(skew_err), .rd_timeout_err(rd_timeout_err)
   );

   always #5 clk = ~clk;

   // ---- reference model -------------------------------------------------
   typedef struct { logic [DBAW-1:0] a; bit inj; bit rmw; } qtag_t;
   localparam int M_CAL = 0, M_RUN = 1, M_HALT = 2;

   qtag_t                tq[$];
   int                   m_st, m_skew, m_age;
   bit                   m_en, m_inj, m_rmw, e_ovf, e_orph, e_skew, e_to;
   logic [DBAW-1:0]      m_addr;
   logic [DBYTES*64-1:0] m_data;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      mcrdCAS = 0; winBuf = '0; winInjTxn = 0; winRmw = 0;
      phy2clb_fifo_empty = '1; phy2clb_rd_dq = '0;
   endtask

   task automatic do_reset();
      rst_n = 0; calDone = 0; idle_inputs();
      tq.delete(); m_st = M_CAL; m_skew = 0; m_age = 0;
      m_en = 0; m_inj = 0; m_rmw = 0; m_addr = '0; m_data = '0;
      e_ovf = 0; e_orph = 0; e_skew = 0; e_to = 0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_outs", {rdDataEn, rdDataEnd, rdInj, rdRmw, tag_ovf_err, orphan_err,
                       skew_err, rd_timeout_err, mc_clb2phy_fifo_rden}, '0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_rddata", rdData, 0);
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   // One clock cycle: inputs already applied just after the previous edge.
   task automatic step();
      bit running, allne, some, pop, newerr;
      int sz;
      qtag_t hd;
      #4;
      running = (m_st == M_RUN) && calDone;
      allne   = (phy2clb_fifo_empty == '0);
      some    = !allne && !(&phy2clb_fifo_empty);
      sz      = tq.size();
      pop     = running && (sz > 0) && allne;
      chk("rden", mc_clb2phy_fifo_rden, pop ? {DBYTES{1'b1}} : '0);
      chk("outstanding_pre", outstanding, sz);
      @(posedge clk);
      newerr = 0;
      m_en = pop;
      if (pop) begin
         hd = tq.pop_front();
         m_addr = hd.a; m_inj = hd.inj; m_rmw = hd.rmw; m_data = phy2clb_rd_dq;
      end else begin
         m_inj = 0; m_rmw = 0;
      end
      if (running && mcrdCAS) begin
         if (sz < TAG_DEPTH || pop) tq.push_back('{winBuf, winInjTxn, winRmw});
         else begin e_ovf = 1; newerr = 1; end
      end
      if (running && allne && sz == 0) begin e_orph = 1; newerr = 1; end
      if (!running || pop || !some) m_skew = 0;
      else if (m_skew < 255) m_skew++;
      if (running && m_skew >= SKEW_MAX + 1) begin e_skew = 1; newerr = 1; end
      if (!running || pop || sz == 0) m_age = 0;
      else if (m_age < 255) m_age++;
      if (running && m_age > int'(max_rd_lat) + TO_MARGIN) begin e_to = 1; newerr = 1; end
      if (m_st == M_CAL || (m_st == M_RUN && !calDone)) tq.delete();
      case (m_st)
         M_CAL:   if (calDone) m_st = M_RUN;
         M_RUN:   if (!calDone) m_st = M_CAL; else if (newerr) m_st = M_HALT;
         default: m_st = M_HALT;
      endcase
      #1;
      chk("rdDataEn", rdDataEn, m_en);
      chk("rdDataEnd", rdDataEnd, m_en);
      if (m_en) chk("rdDataAddr", rdDataAddr, m_addr);
      chk("rdData", rdData, m_data);
      chk("rdInj", rdInj, m_inj);
      chk("rdRmw", rdRmw, m_rmw);
      chk("errs", {tag_ovf_err, orphan_err, skew_err, rd_timeout_err},
                  {e_ovf, e_orph, e_skew, e_to});
      chk("outstanding", outstanding, tq.size());
   endtask

   task automatic cas(input int a, input bit inj, input bit rmw);
      mcrdCAS = 1; winBuf = DBAW'(a); winInjTxn = inj; winRmw = rmw;
      step();
      mcrdCAS = 0; winInjTxn = 0; winRmw = 0;
   endtask

   task automatic lanes(input logic [DBYTES-1:0] emp, input logic [DBYTES*64-1:0] dq);
      phy2clb_fifo_empty = emp; phy2clb_rd_dq = dq;
      step();
      phy2clb_fifo_empty = '1;
   endtask

   function automatic logic [DBYTES*64-1:0] rnd_dq();
      logic [DBYTES*64-1:0] v;
      for (int i = 0; i < DBYTES*2; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [DBYTES*64-1:0] pat;
      max_rd_lat = 7'd40;

      // 1: single read, data 10 cycles later
      do_reset();
      calDone = 1; step();
      cas(5, 0, 0);
      repeat (10) step();
      pat = {(DBYTES*8){8'hA5}};
      lanes('0, pat);
      step();
      chk("t1_addr", rdDataAddr, 5);
      chk("t1_data", rdData, pat);

      // 2: three reads returned back-to-back in order
      do_reset();
      calDone = 1; step();
      cas(1, 1, 0); cas(2, 0, 1); cas(3, 1, 1);
      chk("t2_out3", outstanding, 3);
      phy2clb_fifo_empty = '0;
      for (int i = 0; i < 3; i++) begin
         phy2clb_rd_dq = rnd_dq();
         step();
         chk("t2_addr", rdDataAddr, i + 1);
         chk("t2_out", outstanding, 2 - i);
      end
      idle_inputs(); step();

      // 3: seventeen reads with no return overflow the tag FIFO
      do_reset();
      calDone = 1; step();
      for (int i = 0; i < 17; i++) cas(i, 0, 0);
      chk("t3_ovf", tag_ovf_err, 1);
      chk("t3_out", outstanding, 16);
      cas(7, 0, 0);
      lanes('0, rnd_dq());
      step();

      // 4: lane skew for 16 cycles
      do_reset();
      calDone = 1; step();
      phy2clb_fifo_empty = 4'b1110;
      repeat (15) step();
      chk("t4_skew15", skew_err, 0);
      step();
      chk("t4_skew16", skew_err, 1);
      idle_inputs(); step();

      // 5: read timeout with max_rd_lat = 20
      do_reset();
      max_rd_lat = 7'd20;
      calDone = 1; step();
      cas(9, 0, 0);
      repeat (52) step();
      chk("t5_to52", rd_timeout_err, 0);
      step();
      chk("t5_to53", rd_timeout_err, 1);
      lanes('0, rnd_dq());
      step();
      max_rd_lat = 7'd40;

      // 6: calDone drop flushes tags, then data with no tag is an orphan
      do_reset();
      calDone = 1; step();
      cas(4, 0, 0); cas(6, 0, 0);
      calDone = 0; step();
      chk("t6_flush", outstanding, 0);
      chk("t6_noerr", {tag_ovf_err, orphan_err, skew_err, rd_timeout_err}, 0);
      calDone = 1; step();
      lanes('0, rnd_dq());
      chk("t6_orphan", orphan_err, 1);

      // random traffic segments
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         max_rd_lat = 7'($urandom_range(20, 60));
         for (int c = 0; c < 400; c++) begin
            calDone   = ($urandom_range(0, 99) != 0);
            mcrdCAS   = ($urandom_range(0, 2) == 0);
            winBuf    = DBAW'($urandom);
            winInjTxn = $urandom_range(0, 1) != 0;
            winRmw    = $urandom_range(0, 1) != 0;
            phy2clb_rd_dq = rnd_dq();
            if (tq.size() > 0 && $urandom_range(0, 1) == 1) phy2clb_fifo_empty = '0;
            else if ($urandom_range(0, 19) == 0) phy2clb_fifo_empty = DBYTES'($urandom_range(1, 14));
            else if ($urandom_range(0, 49) == 0) phy2clb_fifo_empty = '0;
            else phy2clb_fifo_empty = '1;
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
